// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 Hz VGA timing generator.
package vga_timing_pkg;

    // Default horizontal timing, in pixel clocks
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    // Default vertical timing, in lines
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Sync delay that matches the registered colour stage downstream
    localparam int DEF_SYNC_DELAY = 1;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Sync windows are half-open: [START, END)
    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel stage.
// There is no handshake: every signal is valid on every pixel clock, and
// the pixel stage simply samples it.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t DrawX;
    coord_t DrawY;
    logic   blank;
    logic   hs;
    logic   vs;
    logic   line_start;
    logic   frame_start;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start
    );

endinterface

// File: rtl/vga_sync_delay.sv
// Two-bit shift register for {hs, vs}. Stages reset to all-ones so that an
// inactive (high) sync level is held while the pipe refills after reset.
module vga_sync_delay #(
    parameter int DEPTH = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_d,
    output logic [1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock and reset are not needed for a straight wire
            logic w_unused;
            assign w_unused = i_clk ^ i_rst_n;
            assign o_q      = i_d;
        end else begin : g_shift
            logic [1:0] r_stage [DEPTH];

            // Shift every cycle; async reset forces syncs inactive at once
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= 2'b11;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered decode of blank, line
// and frame strobes and raw syncs, plus a short delay on hs/vs to line them
// up with the registered colour produced downstream.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int L_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int L_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t L_H_LAST   = coord_t'(L_H_TOTAL - 1);
    localparam coord_t L_V_LAST   = coord_t'(L_V_TOTAL - 1);
    localparam coord_t L_H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t L_V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t L_HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t L_HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t L_VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t L_VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    // r_run is low only until the first edge after reset: that edge loads
    // the decode of (0,0) without advancing, so hc=1 appears one cycle later.
    logic       r_run;
    coord_t     r_hc;
    coord_t     r_vc;
    logic       r_blank;
    logic       r_line_start;
    logic       r_frame_start;
    logic       r_hs_raw;
    logic       r_vs_raw;

    coord_t     w_hc_next;
    coord_t     w_vc_next;
    logic [1:0] w_sync;

    // Next counter values; the decode flops below use these so their
    // outputs line up with the counters they describe
    always_comb begin
        w_hc_next = r_hc;
        w_vc_next = r_vc;
        if (r_run) begin
            if (r_hc == L_H_LAST) begin
                w_hc_next = '0;
                w_vc_next = (r_vc == L_V_LAST) ? '0 : r_vc + 10'd1;
            end else begin
                w_hc_next = r_hc + 10'd1;
            end
        end
    end

    // Counters and glitch-free registered decode
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run         <= 1'b0;
            r_hc          <= '0;
            r_vc          <= '0;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs_raw      <= 1'b1;
            r_vs_raw      <= 1'b1;
        end else begin
            r_run         <= 1'b1;
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            r_blank       <= (w_hc_next < L_H_VIS) && (w_vc_next < L_V_VIS);
            r_line_start  <= (w_hc_next == '0);
            r_frame_start <= (w_hc_next == '0) && (w_vc_next == '0);
            r_hs_raw      <= !((w_hc_next >= L_HS_START) && (w_hc_next < L_HS_END));
            r_vs_raw      <= !((w_vc_next >= L_VS_START) && (w_vc_next < L_VS_END));
        end
    end

    vga_sync_delay #(
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .i_clk   (vga_clk),
        .i_rst_n (reset_n),
        .i_d     ({r_hs_raw, r_vs_raw}),
        .o_q     (w_sync)
    );

    assign vga.DrawX       = r_hc;
    assign vga.DrawY       = r_vc;
    assign vga.blank       = r_blank;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;
    assign vga.hs          = w_sync[1];
    assign vga.vs          = w_sync[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three default-timing builds (sync delay 1, 0, 3)
// and one small-timing build (delay 2) so whole frames fit in a short run.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct {
        int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
        int d;
    } cfg_t;

    typedef struct {
        int x; int y;
        bit blank; bit hs; bit vs; bit ls; bit fs;
    } exp_t;

    typedef struct {
        int n;
        int x; int y;
        bit blank; bit hs; bit vs; bit ls; bit fs;
    } vec_t;

    localparam cfg_t C_D1 = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    localparam cfg_t C_D0 = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    localparam cfg_t C_D3 = '{640, 16, 96, 48, 480, 10, 2, 33, 3};
    localparam cfg_t C_SM = '{10, 2, 3, 3, 6, 2, 2, 3, 2};

    logic vga_clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_cyc   = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   chk_en  = 1'b0;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen_if u_if_d1 ();
    vga_timing_gen_if u_if_d0 ();
    vga_timing_gen_if u_if_d3 ();
    vga_timing_gen_if u_if_sm ();

    vga_timing_gen #(.SYNC_DELAY(1)) u_dut_d1 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(u_if_d1));
    vga_timing_gen #(.SYNC_DELAY(0)) u_dut_d0 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(u_if_d0));
    vga_timing_gen #(.SYNC_DELAY(3)) u_dut_d3 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(u_if_d3));
    vga_timing_gen #(
        .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_DELAY(2)
    ) u_dut_sm (.vga_clk(vga_clk), .reset_n(reset_n), .vga(u_if_sm));

    // Clock edges since reset release; edge 1 is the one showing hc=0
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) n_cyc = 0;
        else          n_cyc = n_cyc + 1;
    end

    // Reference: raster position is just the edge count folded by the
    // line and frame lengths; syncs are the same rule looked up d edges ago
    function automatic exp_t ref_model(cfg_t c, int n);
        exp_t e;
        int   ht;
        int   vt;
        int   k;
        int   hx;
        int   vy;
        ht = c.hv + c.hf + c.hsw + c.hb;
        vt = c.vv + c.vf + c.vsw + c.vb;
        e = '{default: 0};
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (n >= 1) begin
            k       = n - 1;
            e.x     = k % ht;
            e.y     = (k / ht) % vt;
            e.blank = (e.x < c.hv) && (e.y < c.vv);
            e.ls    = (e.x == 0);
            e.fs    = (e.x == 0) && (e.y == 0);
        end
        if (n - c.d >= 1) begin
            k    = n - c.d - 1;
            hx   = k % ht;
            vy   = (k / ht) % vt;
            e.hs = !((hx >= c.hv + c.hf) && (hx < c.hv + c.hf + c.hsw));
            e.vs = !((vy >= c.vv + c.vf) && (vy < c.vv + c.vf + c.vsw));
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, n_cyc, $time);
        end
    endtask

    task automatic cmp_inst(string tag, cfg_t c, logic [9:0] x, logic [9:0] y,
                            logic b, logic h, logic v, logic l, logic f);
        exp_t e;
        e = ref_model(c, n_cyc);
        chk({tag, ".DrawX"},       32'(x), 32'(e.x));
        chk({tag, ".DrawY"},       32'(y), 32'(e.y));
        chk({tag, ".blank"},       32'(b), 32'(e.blank));
        chk({tag, ".hs"},          32'(h), 32'(e.hs));
        chk({tag, ".vs"},          32'(v), 32'(e.vs));
        chk({tag, ".line_start"},  32'(l), 32'(e.ls));
        chk({tag, ".frame_start"}, 32'(f), 32'(e.fs));
    endtask

    // Scoreboard: every build against the reference on every falling edge
    always @(negedge vga_clk) begin
        if (chk_en) begin
            cmp_inst("d1", C_D1, u_if_d1.DrawX, u_if_d1.DrawY, u_if_d1.blank, u_if_d1.hs,
                     u_if_d1.vs, u_if_d1.line_start, u_if_d1.frame_start);
            cmp_inst("d0", C_D0, u_if_d0.DrawX, u_if_d0.DrawY, u_if_d0.blank, u_if_d0.hs,
                     u_if_d0.vs, u_if_d0.line_start, u_if_d0.frame_start);
            cmp_inst("d3", C_D3, u_if_d3.DrawX, u_if_d3.DrawY, u_if_d3.blank, u_if_d3.hs,
                     u_if_d3.vs, u_if_d3.line_start, u_if_d3.frame_start);
            cmp_inst("sm", C_SM, u_if_sm.DrawX, u_if_sm.DrawY, u_if_sm.blank, u_if_sm.hs,
                     u_if_sm.vs, u_if_sm.line_start, u_if_sm.frame_start);
        end
    end

    // Advance to the falling edge after edge 'target'; bounded
    task automatic wait_n(int target);
        int guard;
        guard = 0;
        while (n_cyc < target && guard < 20000) begin
            @(negedge vga_clk);
            guard++;
        end
        if (n_cyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_n: edge count %0d, wanted %0d", n_cyc, target);
        end
    endtask

    task automatic assert_reset_now();
        reset_n = 1'b0;
        #1;
    endtask

    task automatic release_after(int cycles);
        repeat (cycles) @(negedge vga_clk);
        #5 reset_n = 1'b1;
    endtask

    vec_t tbl[12];

    initial begin
        int   fall_d0, fall_d1, fall_d3;
        int   low_d0, low_d1, low_d3, ls_cnt;
        logic p_d0, p_d1, p_d3;
        int   cnt_ls, cnt_fs, cnt_blank, cnt_vs;

        // Hand-derived expectations for the default build (delay 1)
        tbl[0]  = '{1,   0,   0, 1, 1, 1, 1, 1};
        tbl[1]  = '{2,   1,   0, 1, 1, 1, 0, 0};
        tbl[2]  = '{640, 639, 0, 1, 1, 1, 0, 0};
        tbl[3]  = '{641, 640, 0, 0, 1, 1, 0, 0};
        tbl[4]  = '{657, 656, 0, 0, 1, 1, 0, 0};
        tbl[5]  = '{658, 657, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{752, 751, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{753, 752, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{754, 753, 0, 0, 1, 1, 0, 0};
        tbl[9]  = '{800, 799, 0, 0, 1, 1, 0, 0};
        tbl[10] = '{801, 0,   1, 1, 1, 1, 1, 0};
        tbl[11] = '{802, 1,   1, 1, 1, 1, 0, 0};

        // Clock/reset: assert, hold three cycles, check, release
        #1 reset_n = 1'b0;
        @(negedge vga_clk);
        chk_en = 1'b1;
        repeat (2) @(negedge vga_clk);
        chk("rst.DrawX", 32'(u_if_d1.DrawX), 32'd0);
        chk("rst.blank", 32'(u_if_d1.blank), 32'd0);
        chk("rst.hs",    32'(u_if_d3.hs),    32'd1);
        #5 reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wait_n(tbl[i].n);
            chk("tbl.DrawX",       32'(u_if_d1.DrawX),       32'(tbl[i].x));
            chk("tbl.DrawY",       32'(u_if_d1.DrawY),       32'(tbl[i].y));
            chk("tbl.blank",       32'(u_if_d1.blank),       32'(tbl[i].blank));
            chk("tbl.hs",          32'(u_if_d1.hs),          32'(tbl[i].hs));
            chk("tbl.vs",          32'(u_if_d1.vs),          32'(tbl[i].vs));
            chk("tbl.line_start",  32'(u_if_d1.line_start),  32'(tbl[i].ls));
            chk("tbl.frame_start", 32'(u_if_d1.frame_start), 32'(tbl[i].fs));
        end

        // One full line: hs falling position and width per delay build
        fall_d0 = -1; fall_d1 = -1; fall_d3 = -1;
        low_d0 = 0; low_d1 = 0; low_d3 = 0; ls_cnt = 0;
        p_d0 = u_if_d0.hs; p_d1 = u_if_d1.hs; p_d3 = u_if_d3.hs;
        for (int i = 0; i < 800; i++) begin
            @(negedge vga_clk);
            if (p_d0 && !u_if_d0.hs) fall_d0 = int'(u_if_d0.DrawX);
            if (p_d1 && !u_if_d1.hs) fall_d1 = int'(u_if_d1.DrawX);
            if (p_d3 && !u_if_d3.hs) fall_d3 = int'(u_if_d3.DrawX);
            if (!u_if_d0.hs) low_d0++;
            if (!u_if_d1.hs) low_d1++;
            if (!u_if_d3.hs) low_d3++;
            if (u_if_d1.line_start) ls_cnt++;
            p_d0 = u_if_d0.hs; p_d1 = u_if_d1.hs; p_d3 = u_if_d3.hs;
        end
        chk("line.d0_hs_fall_x", 32'(fall_d0), 32'(HS_START));
        chk("line.d1_hs_fall_x", 32'(fall_d1), 32'(HS_START + 1));
        chk("line.d3_hs_fall_x", 32'(fall_d3), 32'(HS_START + 3));
        chk("line.d0_hs_width",  32'(low_d0),  32'(DEF_H_SYNC));
        chk("line.d1_hs_width",  32'(low_d1),  32'(DEF_H_SYNC));
        chk("line.d3_hs_width",  32'(low_d3),  32'(DEF_H_SYNC));
        chk("line.line_starts",  32'(ls_cnt),  32'd1);

        // Async reset in the middle of an hs pulse (line 2, hc=700)
        wait_n(2301);
        #5 assert_reset_now();
        chk("async.d1_hs",    32'(u_if_d1.hs),    32'd1);
        chk("async.d3_hs",    32'(u_if_d3.hs),    32'd1);
        chk("async.d1_DrawX", 32'(u_if_d1.DrawX), 32'd0);
        chk("async.d1_DrawY", 32'(u_if_d1.DrawY), 32'd0);
        chk("async.d1_blank", 32'(u_if_d1.blank), 32'd0);
        release_after($urandom_range(1, 4));

        // Whole small frame: strobe, blank and vs totals, then the wrap
        cnt_ls = 0; cnt_fs = 0; cnt_blank = 0; cnt_vs = 0;
        for (int k = 1; k <= 234; k++) begin
            wait_n(k);
            if (u_if_sm.line_start)  cnt_ls++;
            if (u_if_sm.frame_start) cnt_fs++;
            if (u_if_sm.blank)       cnt_blank++;
            if (!u_if_sm.vs)         cnt_vs++;
        end
        chk("frame.line_starts",  32'(cnt_ls),          32'd13);
        chk("frame.frame_starts", 32'(cnt_fs),          32'd1);
        chk("frame.blank_cycles", 32'(cnt_blank),       32'd60);
        chk("frame.vs_low",       32'(cnt_vs),          32'd36);
        chk("frame.last_DrawX",   32'(u_if_sm.DrawX),   32'd17);
        chk("frame.last_DrawY",   32'(u_if_sm.DrawY),   32'd12);
        wait_n(235);
        chk("frame.wrap_DrawX",   32'(u_if_sm.DrawX),   32'd0);
        chk("frame.wrap_DrawY",   32'(u_if_sm.DrawY),   32'd0);
        chk("frame.wrap_fs",      32'(u_if_sm.frame_start), 32'd1);

        // Async reset while the small build has both vs and hs low
        wait_n(412);
        chk("pre.sm_vs_low", 32'(u_if_sm.vs), 32'd0);
        chk("pre.sm_hs_low", 32'(u_if_sm.hs), 32'd0);
        #5 assert_reset_now();
        chk("async.sm_vs",    32'(u_if_sm.vs),    32'd1);
        chk("async.sm_hs",    32'(u_if_sm.hs),    32'd1);
        chk("async.sm_DrawX", 32'(u_if_sm.DrawX), 32'd0);
        chk("async.sm_DrawY", 32'(u_if_sm.DrawY), 32'd0);
        release_after(2);

        // Pulse is dropped, not resumed: vs stays high until line 8 comes round
        cnt_vs = 0;
        for (int k = 1; k <= 146; k++) begin
            wait_n(k);
            if (!u_if_sm.vs) cnt_vs++;
        end
        chk("resume.sm_vs_low", 32'(cnt_vs), 32'd0);
        wait_n(147);
        chk("resume.sm_vs_start", 32'(u_if_sm.vs), 32'd0);

        // Random run lengths and reset instants anywhere in the low phase
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(50, 700)) @(negedge vga_clk);
            #($urandom_range(1, 15));
            assert_reset_now();
            chk("rand.d1_hs",    32'(u_if_d1.hs),    32'd1);
            chk("rand.d0_vs",    32'(u_if_d0.vs),    32'd1);
            chk("rand.sm_hs",    32'(u_if_sm.hs),    32'd1);
            chk("rand.sm_vs",    32'(u_if_sm.vs),    32'd1);
            chk("rand.d1_DrawX", 32'(u_if_d1.DrawX), 32'd0);
            release_after($urandom_range(1, 3));
        end
        repeat (300) @(negedge vga_clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives DrawX/DrawY/blank into the sprite/palette pixel stage. That stage registers its colour one cycle after ROM lookup, so this block also drives the monitor hs/vs.
- Sync outputs are delayed by a configurable number of cycles so they stay aligned with the registered colour outputs downstream.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pipeline cycles added to hs/vs (0..4); matches downstream colour latency

Ports:
- vga_clk  input  1  pixel clock, 25 MHz
- reset_n  input  1  asynchronous, active-low reset
- DrawX  output  10  current horizontal counter value, 0..H_TOTAL-1
- DrawY  output  10  current vertical counter value, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (display enabled), 0 = porch/sync
- hs  output  1  horizontal sync, active low, delayed SYNC_DELAY cycles
- vs  output  1  vertical sync, active low, delayed SYNC_DELAY cycles
- line_start  output  1  one-cycle pulse while DrawX==0
- frame_start  output  1  one-cycle pulse while DrawX==0 and DrawY==0

Behaviour:
- H_TOTAL = sum of H_* parameters = 800. V_TOTAL = sum of V_* parameters = 525. All comparisons are unsigned at 10 bits.
- Registers hc and vc. DrawX = hc and DrawY = vc, driven directly from the flops.
- hc increments every cycle. At hc==H_TOTAL-1 it wraps to 0 and vc advances. vc increments only on that wrap; at vc==V_TOTAL-1 (on the same wrap) it wraps to 0.
- Last cycle of a frame: hc=799, vc=524. Next cycle: hc=0, vc=0.
- blank, line_start, frame_start and the internal hs_raw/vs_raw are flops computed from next-state counters. They are therefore aligned with and decoded from the current hc/vc, with no combinational glitch.
  - blank = (hc < H_VISIBLE) && (vc < V_VISIBLE)
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751
  - vs_raw = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491, for the whole of those lines
- hs/vs are hs_raw/vs_raw passed through a SYNC_DELAY-stage shift register. With SYNC_DELAY=0, hs=hs_raw and vs=vs_raw directly.
- blank and DrawX/DrawY are never delayed; downstream applies its own latency.
- Reset (reset_n=0, asynchronous, any time, including mid-line or mid-frame):
  - hc=0, vc=0, blank=0, hs=1, vs=1, line_start=0, frame_start=0.
  - Every delay stage is reset to 1, so no spurious sync pulse appears after release.
- First rising edge after reset_n deasserts: flops load their decode of hc=0/vc=0 and counting starts.
  - Required from the cycle after release: blank=1, line_start=1, frame_start=1.
  - hc=1 on the following cycle.
- Sync pulse counts per frame: exactly one vs low pulse of V_SYNC*H_TOTAL = 1600 cycles, and exactly one hs low pulse of H_SYNC = 96 cycles per line.
- The delay line shifts every cycle. A reset asserted during a pulse forces hs/vs high at once; after release the pulse is lost, not resumed.

Decomposition:
- Package vga_timing_pkg holds:
  - the default H_*/V_* constants
  - H_TOTAL and V_TOTAL
  - localparams HS_START/HS_END/VS_START/VS_END
  - typedef coord_t (logic [9:0])
- One sub-module, vga_sync_delay: parameterised DEPTH, 2-bit wide shift register with async active-low reset to all-ones. DEPTH=0 is a pass-through. It is instantiated once for {hs_raw, vs_raw}.
- The counters and decode stay in vga_timing_gen.

Test Plan:
- Reset release, default params -> DrawX=0, DrawY=0, blank=1, frame_start=1, hs=1, vs=1. Next cycle DrawX=1, frame_start=0.
- Run one line -> DrawX counts 0..799 then wraps to 0 with DrawY=1. blank=1 for DrawX 0..639, 0 for 640..799. hs_raw low for hc 656..751; hs low 1 cycle later (657..752 in hc terms), width 96.
- Run a full frame -> DrawY wraps 524->0 after 420000 cycles. vs low for 1600 consecutive cycles starting 1 cycle after (hc=0, vc=490). frame_start pulses exactly once. line_start pulses 525 times.
- blank check over a frame -> blank low for all of lines 480..524. Exactly 307200 blank=1 cycles per frame.
- Assert reset_n=0 asynchronously at hc=700, vc=491 (during vs and hs low) -> hs=1, vs=1, DrawX=0, DrawY=0 immediately, without waiting for a clock edge. After release no vs pulse until vc=490.
- SYNC_DELAY=0 and SYNC_DELAY=3 builds -> hs falling edge observed with hc=656 and hc=659 respectively. Pulse widths are unchanged.
